// File: rtl/bit_serial_adder_if.sv
// Handshake and operand/result bundle between a controller and bit_serial_adder.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first,
// one operand bit per clock.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// ADD   | shifting one bit pair per clock through the full adder
// DONE  | one-cycle result-valid pulse, then back to IDLE
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  bit_serial_adder_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_r;
  logic             carry;
  logic             cout_r;
  logic [CW-1:0]    count;

  logic fa_s;
  logic fa_co;

  // Full-adder cell on the current LSBs and the registered carry.
  always_comb begin
    fa_s  = a_sr[0] ^ b_sr[0] ^ carry;
    fa_co = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  end

  // Sequencer, operand shifters, carry flop and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            sum_r <= '0;
            count <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          carry <= fa_co;
          sum_r <= {fa_s, sum_r[WIDTH-1:1]};
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          if (count == LAST) begin
            // Wrap rather than increment so count never passes WIDTH-1.
            count  <= '0;
            cout_r <= fa_co;
            state  <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status is decoded from registered state only.
  always_comb begin
    bus.busy = (state == ADD);
    bus.done = (state == DONE);
    bus.sum  = sum_r;
    bus.cout = cout_r;
  end
endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder at WIDTH=8 and WIDTH=16.
module tb_bit_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  bit_serial_adder_if #(.WIDTH(8))  bus8 ();
  bit_serial_adder_if #(.WIDTH(16)) bus16 ();

  bit_serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  bit_serial_adder #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t tbl [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One complete 8-bit operation; operands are scrambled right after acceptance.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [7:0] exp_s, input logic exp_co);
    int lat;
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    tick();
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    lat = 0;
    while (!bus8.done && lat < 20) begin
      tick();
      lat++;
    end
    chk("w8_latency", 32'(lat), 32'd8);
    chk("w8_sum", 32'(bus8.sum), 32'(exp_s));
    chk("w8_cout", 32'(bus8.cout), 32'(exp_co));
    tick();
    chk("w8_done_width", 32'(bus8.done), 32'd0);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int lat;
    logic [16:0] model;
    model = 17'(a) + 17'(b) + 17'(cin);
    bus16.start = 1'b1; bus16.a = a; bus16.b = b; bus16.cin = cin;
    tick();
    bus16.start = 1'b0; bus16.a = 16'($urandom); bus16.b = 16'($urandom);
    lat = 0;
    while (!bus16.done && lat < 40) begin
      tick();
      lat++;
    end
    chk("w16_latency", 32'(lat), 32'd16);
    chk("w16_result", 32'({bus16.cout, bus16.sum}), 32'(model));
    tick();
    chk("w16_done_width", 32'(bus16.done), 32'd0);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rc;
    logic [8:0]  m8;
    int          nd;
    int          dt [2];
    logic        seen;

    tbl[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, co: 1'b0};
    tbl[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, co: 1'b1};
    tbl[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, co: 1'b1};
    tbl[3] = '{a: 8'h00, b: 8'h00, cin: 1'b0, s: 8'h00, co: 1'b0};
    tbl[4] = '{a: 8'h80, b: 8'h80, cin: 1'b1, s: 8'h01, co: 1'b1};
    tbl[5] = '{a: 8'h55, b: 8'hAA, cin: 1'b0, s: 8'hFF, co: 1'b0};
    tbl[6] = '{a: 8'h55, b: 8'hAA, cin: 1'b1, s: 8'h00, co: 1'b1};

    bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.cin = 1'b0;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(bus8.busy), 32'd0);
    chk("rst_done", 32'(bus8.done), 32'd0);
    chk("rst_sum", 32'(bus8.sum), 32'd0);
    chk("rst_cout", 32'(bus8.cout), 32'd0);
    chk("rst16_result", 32'({bus16.cout, bus16.sum}), 32'd0);

    // Cycle-by-cycle busy/done for 0x0F+0x01, with an ignored start at E3.
    bus8.start = 1'b1; bus8.a = 8'h0F; bus8.b = 8'h01; bus8.cin = 1'b0;
    tick();
    bus8.start = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      chk("seq_busy", 32'(bus8.busy), 32'(k < 8));
      chk("seq_done", 32'(bus8.done), 32'(k == 8));
      if (k == 2) begin
        bus8.start = 1'b1; bus8.a = 8'hAA; bus8.b = 8'h55; bus8.cin = 1'b1;
      end
      if (k == 3) bus8.start = 1'b0;
      if (k < 8) tick();
    end
    chk("seq_sum", 32'(bus8.sum), 32'h10);
    chk("seq_cout", 32'(bus8.cout), 32'd0);
    tick();
    chk("seq_done_drop", 32'(bus8.done), 32'd0);
    tick();

    for (int i = 0; i < 7; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co);
      tick();
    end

    // Abort mid-ADD with reset and start asserted together at E4.
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    tick();
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF; bus8.cin = 1'b1;
    tick();
    bus8.start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; bus8.start = 1'b1;
    tick();
    rst = 1'b0; bus8.start = 1'b0;
    chk("abort_busy", 32'(bus8.busy), 32'd0);
    chk("abort_done", 32'(bus8.done), 32'd0);
    chk("abort_sum", 32'(bus8.sum), 32'd0);
    chk("abort_cout", 32'(bus8.cout), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus8.done || bus8.busy) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    // start held high: back-to-back acceptance every WIDTH+2 cycles.
    bus8.start = 1'b1; bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0;
    nd = 0;
    dt[0] = -1; dt[1] = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus8.done) begin
        if (nd < 2) dt[nd] = i;
        nd++;
        chk("held_sum", 32'(bus8.sum), 32'h46);
      end
    end
    bus8.start = 1'b0;
    chk("held_count", 32'(nd), 32'd2);
    chk("held_first", 32'(dt[0]), 32'd8);
    chk("held_second", 32'(dt[1]), 32'd18);
    tick(); tick();

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      m8 = 9'(ra) + 9'(rb) + 9'(rc);
      run8(ra, rb, rc, m8[7:0], m8[8]);
    end
    for (int i = 0; i < 1000; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
